// File: rtl/fetch_unit.sv
// fetch_unit -- sequential instruction fetch from a synchronous ROM.
//
// Waits for the ROM loader to finish, then walks addresses 0..i_max_addr,
// issuing one ROM read at a time and holding each fetched instruction on
// o_instr/o_pc until decode accepts it (o_valid & i_ready). Branch/jump
// redirects restart fetch at a new address; targets beyond i_max_addr halt.
//
// Ports:
//   i_clk            system clock (shared with the ROM read side)
//   i_rst            synchronous active-high reset
//   i_load_done      ROM load complete; starts fetch from address 0
//   i_max_addr       address of the last valid instruction
//   i_rom_instr      ROM read data, valid the cycle after o_rom_en
//   o_rom_en         ROM read enable (one-cycle pulse per fetch)
//   o_rom_addr       ROM read address
//   o_instr, o_pc    fetched instruction and its address
//   o_valid          o_instr/o_pc valid
//   i_ready          decode accepts the presented instruction
//   i_redirect       branch/jump request
//   i_redirect_addr  redirect target address
//   o_halted         fetch has ended (past i_max_addr or out-of-range target)
//   o_fetch_count    delivered-instruction count
//
// Build option:
//   FETCH_PERF_CNT_EN  defined   -> o_fetch_count counts handshakes, saturating
//                      undefined -> no counter, o_fetch_count tied to zero

module fetch_unit (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_load_done,
  input  logic [7:0]  i_max_addr,
  input  logic [15:0] i_rom_instr,
  output logic        o_rom_en,
  output logic [7:0]  o_rom_addr,
  output logic [15:0] o_instr,
  output logic [7:0]  o_pc,
  output logic        o_valid,
  input  logic        i_ready,
  input  logic        i_redirect,
  input  logic [7:0]  i_redirect_addr,
  output logic        o_halted,
  output logic [15:0] o_fetch_count
);

  typedef enum logic [2:0] {
    WAIT_LOAD,
    ISSUE,
    WAIT_DATA,
    HOLD,
    HALT
  } state_t;

  state_t     state;
  logic [7:0] pc;
  logic [7:0] pc_next;

  logic handshake;
  logic redirect_take;
  logic redirect_oob;
  logic at_last;

  assign handshake     = o_valid & i_ready;
  // Redirects are meaningless before the ROM is loaded.
  assign redirect_take = i_redirect & (state != WAIT_LOAD);
  assign redirect_oob  = (i_redirect_addr > i_max_addr);
  // >= rather than == so pc can never walk past the end (and wrap) even if
  // i_max_addr is lowered while an instruction is held.
  assign at_last       = (pc >= i_max_addr);
  assign pc_next       = pc + 8'd1;

  // Outputs are registered: o_rom_en is raised on the edge that enters
  // ISSUE, so the ROM samples it at the end of ISSUE and its data is
  // captured at the end of WAIT_DATA.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= WAIT_LOAD;
      pc         <= '0;
      o_rom_en   <= 1'b0;
      o_rom_addr <= '0;
      o_instr    <= '0;
      o_pc       <= '0;
      o_valid    <= 1'b0;
      o_halted   <= 1'b0;
    end else begin
      o_rom_en <= 1'b0;

      if (redirect_take) begin
        // Wins over a same-cycle handshake; any read in flight is dropped
        // because WAIT_DATA is not reached for it.
        pc      <= i_redirect_addr;
        o_valid <= 1'b0;
        if (redirect_oob) begin
          state    <= HALT;
          o_halted <= 1'b1;
        end else begin
          state      <= ISSUE;
          o_halted   <= 1'b0;
          o_rom_en   <= 1'b1;
          o_rom_addr <= i_redirect_addr;
        end
      end else begin
        case (state)
          WAIT_LOAD: begin
            if (i_load_done) begin
              pc         <= '0;
              state      <= ISSUE;
              o_rom_en   <= 1'b1;
              o_rom_addr <= '0;
            end
          end

          ISSUE: begin
            state <= WAIT_DATA;
          end

          WAIT_DATA: begin
            o_instr <= i_rom_instr;
            o_pc    <= pc;
            o_valid <= 1'b1;
            state   <= HOLD;
          end

          HOLD: begin
            if (handshake) begin
              o_valid <= 1'b0;
              if (at_last) begin
                state    <= HALT;
                o_halted <= 1'b1;
              end else begin
                pc         <= pc_next;
                state      <= ISSUE;
                o_rom_en   <= 1'b1;
                o_rom_addr <= pc_next;
              end
            end
          end

          HALT: begin
            state <= HALT;
          end

          default: begin
            state <= WAIT_LOAD;
          end
        endcase
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_fetch_count <= '0;
    end else if (handshake && (o_fetch_count != 16'hFFFF)) begin
      o_fetch_count <= o_fetch_count + 16'd1;
    end
  end
`else
  assign o_fetch_count = '0;
`endif

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have ports: i_clk  input  1  system clock (100 MHz, same clock as instruction ROM read side).
REQ-002 SHALL have: i_rst  input  1  reset, synchronous, active-high; one clock, no other clock domains.
REQ-003 SHALL have: i_load_done  input  1  instruction ROM transmit-done flag.
REQ-004 SHALL have: i_max_addr  input  8  address of last valid instruction in ROM.
REQ-005 SHALL have: i_rom_instr  input  16  ROM read data, valid 1 cycle after o_rom_en.
REQ-006 SHALL have: o_rom_en  output  1  ROM read enable; o_rom_addr  output  8  ROM read address.
REQ-007 SHALL have: o_instr  output  16  fetched instruction; o_pc  output  8  its address.
REQ-008 SHALL have: o_valid  output  1  o_instr/o_pc valid; i_ready  input  1  decode accepts.
REQ-009 SHALL have: i_redirect  input  1  branch/jump request; i_redirect_addr  input  8  target.
REQ-010 SHALL have: o_halted  output  1  fetch ended; o_fetch_count  output  16  delivered-instruction count.

Function
REQ-011 SHALL implement states WAIT_LOAD, ISSUE, WAIT_DATA, HOLD, HALT.
REQ-012 WAIT_LOAD: o_rom_en=0, o_valid=0; on i_load_done=1 SHALL set pc=0 and go to ISSUE next cycle.
REQ-013 ISSUE: o_rom_en=1 and o_rom_addr=pc for exactly one cycle; next state WAIT_DATA.
REQ-014 WAIT_DATA: SHALL register i_rom_instr into o_instr, pc into o_pc, set o_valid=1; next state HOLD.
REQ-015 HOLD: o_valid, o_instr, o_pc SHALL stay stable until o_valid&i_ready.
REQ-016 On handshake in HOLD: if pc==i_max_addr go HALT, else pc=pc+1 (8-bit) and go ISSUE; o_valid=0 the following cycle.
REQ-017 Latency: o_valid SHALL rise 2 cycles after o_rom_en; steady throughput 1 instruction per 3 cycles with i_ready=1.
REQ-018 HALT: o_halted=1, o_valid=0, o_rom_en=0; remain until redirect or reset.
REQ-019 i_redirect=1 in ISSUE/WAIT_DATA/HOLD/HALT SHALL: drop o_valid next cycle, discard any in-flight ROM data, load pc=i_redirect_addr, clear o_halted, go ISSUE.
REQ-020 If i_redirect_addr > i_max_addr, redirect SHALL go to HALT instead of ISSUE.
REQ-021 Redirect SHALL take priority over simultaneous handshake; the handshaked instruction still counts as delivered.
REQ-022 i_redirect in WAIT_LOAD SHALL be ignored; i_load_done SHALL be ignored outside WAIT_LOAD.
REQ-023 pc SHALL never wrap: i_max_addr=8'hFF halts after address 8'hFF is delivered.

Reset
REQ-024 On i_rst=1 at a clock edge: state=WAIT_LOAD, pc=0, o_rom_en=0, o_rom_addr=0, o_instr=0, o_pc=0, o_valid=0, o_halted=0, o_fetch_count=0.
REQ-025 Reset mid-operation SHALL abandon any pending ROM read and held instruction without further handshake.

Configuration
REQ-026 Macro FETCH_PERF_CNT_EN defined: o_fetch_count SHALL increment (saturating at 16'hFFFF) on every o_valid&i_ready.
REQ-027 Macro FETCH_PERF_CNT_EN undefined: counter SHALL not be built; o_fetch_count SHALL be constant 0.

Verification
REQ-028 Load ROM 0..3 = 16'h1111,2222,3333,4444, i_max_addr=3, i_ready=1, pulse i_load_done -> o_instr 1111..4444 with o_pc 0..3, 3 cycles apart, then o_halted=1; o_fetch_count=4 with macro, 0 without.
REQ-029 Same ROM, i_ready=0 for 10 cycles at pc=1 -> o_valid=1, o_instr=16'h2222 stable all 10 cycles, no o_rom_en pulse.
REQ-030 i_redirect=1, addr=0 on same cycle as handshake of pc=2 -> pc=2 counted, next delivered o_pc=0, o_instr=16'h1111.
REQ-031 In HALT, i_redirect addr=1 -> o_halted=0, delivery resumes at o_pc=1; redirect addr=9 (>max 3) -> o_halted=1, no o_rom_en.
REQ-032 Assert i_rst during WAIT_DATA -> next cycle all outputs at reset values, state WAIT_LOAD, data of aborted read never appears on o_instr.
